// File: rtl/uart_rx_fifo_if.sv
// Purpose : bundles the UART-side capture handshake and the core-side FIFO read port.
// Latency : none; this is wiring only.
// Backpressure : the FIFO holds clear_rx low until it has taken the byte; the core paces reads with pop edges.
// Ports (slave = FIFO side):
//   rx_data, rx_data_ready -> in    byte and level flag from the UART
//   clear_rx               -> out   acknowledge back to the UART
//   pop, clr_ovf           -> in    core read request (edge-detected) and overflow clear
//   rd_data, rd_valid      -> out   head of FIFO and not-empty flag
//   count, overflow        -> out   fill level and sticky drop flag
//   almost_full            -> out   only when UART_RX_FIFO_AFULL_EN is defined
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_data_ready;
  logic                  clear_rx;
  logic                  pop;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [ADDR_W:0]       count;
  logic                  overflow;
  logic                  clr_ovf;
`ifdef UART_RX_FIFO_AFULL_EN
  logic                  almost_full;
`endif

  modport slave (
    input  rx_data, rx_data_ready, pop, clr_ovf,
`ifdef UART_RX_FIFO_AFULL_EN
    output almost_full,
`endif
    output clear_rx, rd_data, rd_valid, count, overflow
  );

  modport master (
    output rx_data, rx_data_ready, pop, clr_ovf,
`ifdef UART_RX_FIFO_AFULL_EN
    input  almost_full,
`endif
    input  clear_rx, rd_data, rd_valid, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Purpose : captures each UART byte once, acks it via clear_rx, queues it for the core.
// Latency : byte visible on rd_data the cycle after capture; clear_rx rises that same cycle.
// Backpressure : none toward the UART; a byte arriving with the FIFO full is dropped and flags overflow.
// Ports: clk, reset (synchronous, active-high), bus (uart_rx_fifo_if.slave).
// Optional feature macro: UART_RX_FIFO_AFULL_EN adds almost_full = (count >= AFULL_LEVEL),
// registered alongside count.
module uart_rx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = 12
) (
  input  logic            clk,
  input  logic            reset,
  uart_rx_fifo_if.slave   bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  capture;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
  logic [ADDR_W:0]       count_q, count_d;
  logic                  pop_q;
  logic                  pop_evt;
  logic                  do_pop, do_push, drop;
  logic                  empty, full;
  logic                  overflow_q;

  // Capture FSM: one push per UART byte; ACK waits for the UART to drop its flag.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: if (bus.rx_data_ready) begin
        capture = 1'b1;
        state_d = ACK;
      end
      ACK:  if (!bus.rx_data_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // clear_rx comes straight off the state register, so it is glitch-free.
  assign bus.clear_rx = (state_q == ACK);

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign pop_evt = bus.pop & ~pop_q;
  assign do_pop  = pop_evt & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = capture & (~full | do_pop);
  assign drop    = capture & full & ~do_pop;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      pop_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pop_q   <= bus.pop;
      count_q <= count_d;
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      // Set has priority so a drop coinciding with a clear is never lost.
      if (drop)             overflow_q <= 1'b1;
      else if (bus.clr_ovf) overflow_q <= 1'b0;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= bus.rx_data;
  end

  assign bus.rd_data  = empty ? '0 : mem[rd_ptr];
  assign bus.rd_valid = ~empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;

`ifdef UART_RX_FIFO_AFULL_EN
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LEVEL);
  logic afull_q;

  always_ff @(posedge clk) begin
    if (reset) afull_q <= 1'b0;
    else       afull_q <= (count_d >= AFULL_CNT);
  end

  assign bus.almost_full = afull_q;
`endif
endmodule
